transmitter_native: RTL and testbench

TRANSMITTER_NATIVE -- requirements
Module: transmitter_native

---
 rtl/simple_uart_pkg.sv | 18 +
 rtl/baud_tick.sv | 30 +++
 rtl/transmitter_native.sv | 97 +++++++++
 tb/tb_transmitter_native.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_uart_pkg.sv
// rtl/simple_uart_pkg.sv - shared UART state type and bit-period helper
package simple_uart_pkg;

    typedef enum logic [1:0] {
        STATE_WAIT,
        STATE_READ_WORD,
        STATE_LOAD_WORD,
        STATE_SEND_BITS
    } uart_state_t;

    function automatic logic [31:0] bit_period(
        input logic [31:0] clock_frequency,
        input logic [31:0] baud_rate
    );
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/baud_tick.sv
// rtl/baud_tick.sv - bit-period down-counter with one-cycle tick at period end
module baud_tick #(
    parameter logic [31:0] PERIOD = 32'd868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (PERIOD > 32'd1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 32'd1);

    logic [CW-1:0] count;

    // Clear preloads the full period so the first tick lands exactly PERIOD cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= LAST;
        end else if (enable) begin
            count <= (count == '0) ? LAST : count - CW'(1);
        end
    end

    assign tick = enable && (count == '0);

endmodule

// File: rtl/transmitter_native.sv
// rtl/transmitter_native.sv - FIFO-fed UART transmitter, 8N1-style framing
module transmitter_native
    import simple_uart_pkg::*;
#(
    parameter logic [31:0] CLOCK_FREQUENCY = 32'd100_000_000,
    parameter logic [31:0] BAUD_RATE       = 32'd115200,
    parameter logic [31:0] WORD_WIDTH      = 32'd8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_WIDTH-1:0] din,
    input  logic                  empty,
    output logic                  re,
    output logic                  dout,
    output logic                  busy
);

    localparam logic [31:0] BIT_PERIOD = bit_period(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int FRAME_BITS = int'(WORD_WIDTH) + 2;
    localparam int IW = $clog2(FRAME_BITS);
    localparam logic [IW-1:0] LAST_INDEX = IW'(FRAME_BITS - 1);

    uart_state_t state, state_next;
    logic [FRAME_BITS-1:0] shreg, shreg_next;
    logic [IW-1:0] index, index_next;
    logic re_next, dout_next, busy_next;
    logic clear, tick, sending;

    assign sending = (state == STATE_SEND_BITS);

    baud_tick #(
        .PERIOD(BIT_PERIOD)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .enable(sending),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STATE_WAIT;
            shreg <= '0;
            index <= '0;
            re    <= 1'b0;
            dout  <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            shreg <= shreg_next;
            index <= index_next;
            re    <= re_next;
            dout  <= dout_next;
            busy  <= busy_next;
        end
    end

    // Outputs are derived from the next state so they can be registered without a cycle of lag.
    always_comb begin
        state_next = state;
        shreg_next = shreg;
        index_next = index;
        clear      = 1'b0;
        case (state)
            STATE_WAIT: begin
                if (!empty) state_next = STATE_READ_WORD;
            end
            STATE_READ_WORD: begin
                state_next = STATE_LOAD_WORD;
            end
            STATE_LOAD_WORD: begin
                shreg_next = {1'b1, din, 1'b0};
                index_next = '0;
                clear      = 1'b1;
                state_next = STATE_SEND_BITS;
            end
            STATE_SEND_BITS: begin
                if (tick) begin
                    shreg_next = shreg >> 1;
                    if (index == LAST_INDEX) begin
                        state_next = STATE_WAIT;
                    end else begin
                        index_next = index + IW'(1);
                    end
                end
            end
            default: begin
                state_next = STATE_WAIT;
            end
        endcase
        re_next   = (state_next == STATE_READ_WORD);
        busy_next = (state_next != STATE_WAIT);
        dout_next = (state_next == STATE_SEND_BITS) ? shreg_next[0] : 1'b1;
    end

endmodule

// File: tb/tb_transmitter_native.sv
// tb/tb_transmitter_native.sv - self-checking bench for transmitter_native
module tb_transmitter_native;

    localparam int NDUT = 2;
    localparam int BP_A = 868;
    localparam int BP_B = 10;

    typedef struct {
        logic [7:0] word;
        logic [9:0] pattern;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] din [NDUT];
    logic [NDUT-1:0] empty;
    logic [NDUT-1:0] re;
    logic [NDUT-1:0] dout;
    logic [NDUT-1:0] busy;

    logic [7:0] f_din [NDUT];
    logic [NDUT-1:0] f_empty = '1;
    logic ovr = 1'b0;
    logic ovr_empty = 1'b1;
    logic [7:0] ovr_din = 8'h00;

    logic [7:0] fq [NDUT][$];
    int re_log [NDUT][$];
    int st_log [NDUT][$];
    logic [9:0] pat_log [NDUT][$];

    bit active [NDUT];
    int mon_n [NDUT];
    int mon_start [NDUT];
    logic [9:0] mon_pat [NDUT];
    bit mon_glitch [NDUT];
    int busy_until [NDUT];
    int glitch_cnt [NDUT];
    int busy_err [NDUT];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    assign empty[0] = ovr ? ovr_empty : f_empty[0];
    assign din[0]   = ovr ? ovr_din : f_din[0];
    assign empty[1] = f_empty[1];
    assign din[1]   = f_din[1];

    transmitter_native u_dut_a (
        .clk(clk), .rst_n(rst_n), .din(din[0]), .empty(empty[0]),
        .re(re[0]), .dout(dout[0]), .busy(busy[0])
    );

    transmitter_native #(
        .CLOCK_FREQUENCY(32'd1000),
        .BAUD_RATE(32'd100),
        .WORD_WIDTH(32'd8)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .din(din[1]), .empty(empty[1]),
        .re(re[1]), .dout(dout[1]), .busy(busy[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic int bp(input int g);
        return (g == 0) ? BP_A : BP_B;
    endfunction

    function automatic logic [9:0] frame_of(input logic [7:0] w);
        logic [9:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i + 1] = w[i];
        f[9] = 1'b1;
        return f;
    endfunction

    // Upstream FIFO model plus a line receiver that checks every sample of each bit period.
    always @(negedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            if (re[g] && fq[g].size() > 0) f_din[g] = fq[g].pop_front();
            f_empty[g] = (fq[g].size() == 0);
            if (!rst_n) begin
                active[g] = 1'b0;
                busy_until[g] = -1;
            end else begin
                if (re[g]) begin
                    re_log[g].push_back(cyc);
                    busy_until[g] = cyc + 1 + 10 * bp(g);
                end
                if (busy[g] !== (cyc <= busy_until[g])) busy_err[g]++;
                if (!active[g] && dout[g] === 1'b0) begin
                    active[g] = 1'b1;
                    mon_n[g] = 0;
                    mon_start[g] = cyc;
                    mon_glitch[g] = 1'b0;
                    mon_pat[g] = '0;
                end
                if (active[g]) begin
                    if (mon_n[g] % bp(g) == 0) mon_pat[g][mon_n[g] / bp(g)] = dout[g];
                    else if (dout[g] !== mon_pat[g][mon_n[g] / bp(g)]) mon_glitch[g] = 1'b1;
                    mon_n[g]++;
                    if (mon_n[g] == 10 * bp(g)) begin
                        active[g] = 1'b0;
                        pat_log[g].push_back(mon_pat[g]);
                        st_log[g].push_back(mon_start[g]);
                        if (mon_glitch[g]) glitch_cnt[g]++;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_frames(input int g, input int n, input int budget, input string name);
        int k;
        k = 0;
        while (pat_log[g].size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        check({name, "_frames"}, pat_log[g].size(), n);
    endtask

    task automatic wait_re(input int g, input int n, input int budget, input string name);
        int k;
        k = 0;
        while (re_log[g].size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        check({name, "_re"}, re_log[g].size(), n);
    endtask

    vec_t vecs [6];
    logic [7:0] rnd_words [16];

    initial begin
        int bad;
        int base;
        int rbase;

        vecs[0] = '{8'h00, 10'b1000000000};
        vecs[1] = '{8'hFF, 10'b1111111110};
        vecs[2] = '{8'h55, 10'b1010101010};
        vecs[3] = '{8'h01, 10'b1000000010};
        vecs[4] = '{8'h80, 10'b1100000000};
        vecs[5] = '{8'hA5, 10'b1101001010};
        for (int g = 0; g < NDUT; g++) begin
            busy_until[g] = -1;
            glitch_cnt[g] = 0;
            busy_err[g] = 0;
            f_din[g] = 8'h00;
        end

        repeat (3) @(negedge clk);
        check("reset_dout_a", int'(dout[0]), 1);
        check("reset_re_a", int'(re[0]), 0);
        check("reset_busy_a", int'(busy[0]), 0);
        check("reset_dout_b", int'(dout[1]), 1);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            fq[1].push_back(vecs[i].word);
            wait_frames(1, i + 1, 300, "table");
            if (pat_log[1].size() > i) check("table_pattern", int'(pat_log[1][i]), int'(vecs[i].pattern));
        end
        check("table_re_count", re_log[1].size(), 6);

        fq[0].push_back(8'hA5);
        wait_frames(0, 1, 9000, "a5");
        check("a5_re_count", re_log[0].size(), 1);
        if (pat_log[0].size() > 0) check("a5_pattern", int'(pat_log[0][0]), int'(10'b1101001010));
        if (st_log[0].size() > 0) check("a5_re_to_start", st_log[0][0] - re_log[0][0], 2);
        repeat (5) @(negedge clk);
        check("a5_idle_dout", int'(dout[0]), 1);
        check("a5_idle_busy", int'(busy[0]), 0);

        bad = 0;
        repeat (10000) begin
            @(negedge clk);
            if (dout[0] !== 1'b1 || re[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
        end
        check("idle_10000_bad_cycles", bad, 0);
        check("idle_re_count", re_log[0].size(), 1);

        fq[0].push_back(8'h00);
        fq[0].push_back(8'hFF);
        wait_frames(0, 3, 18000, "b2b");
        check("b2b_re_count", re_log[0].size(), 3);
        if (re_log[0].size() >= 3) check("b2b_re_spacing", re_log[0][2] - re_log[0][1], 10 * BP_A + 3);
        if (st_log[0].size() >= 3) check("b2b_idle_gap", st_log[0][2] - st_log[0][1] - 10 * BP_A, 3);
        if (pat_log[0].size() >= 3) begin
            check("b2b_pattern_00", int'(pat_log[0][1]), int'(10'b1000000000));
            check("b2b_pattern_ff", int'(pat_log[0][2]), int'(10'b1111111110));
        end

        fq[0].push_back(8'h55);
        wait_re(0, 4, 200, "rst");
        repeat (4000) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_dout_async", int'(dout[0]), 1);
        check("rst_re_async", int'(re[0]), 0);
        check("rst_busy_async", int'(busy[0]), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (2000) begin
            @(negedge clk);
            if (dout[0] !== 1'b1 || re[0] !== 1'b0) bad++;
        end
        check("rst_no_resume", bad, 0);
        check("rst_no_frame", pat_log[0].size(), 3);
        fq[0].push_back(8'h3C);
        wait_frames(0, 4, 9000, "post_rst");
        if (pat_log[0].size() >= 4) check("post_rst_pattern", int'(pat_log[0][3]), int'(10'b1001111000));

        fq[0].push_back(8'hC3);
        wait_re(0, 6, 300, "ignore");
        repeat (5) @(negedge clk);
        ovr = 1'b1;
        repeat (3000) begin
            @(negedge clk);
            ovr_empty = 1'($urandom);
            ovr_din = 8'($urandom);
        end
        ovr_empty = 1'b1;
        ovr = 1'b0;
        wait_frames(0, 5, 9000, "ignore");
        check("ignore_re_count", re_log[0].size(), 6);
        if (pat_log[0].size() >= 5) check("ignore_pattern", int'(pat_log[0][4]), int'(frame_of(8'hC3)));

        base = pat_log[1].size();
        rbase = re_log[1].size();
        for (int i = 0; i < 16; i++) begin
            rnd_words[i] = 8'($urandom);
            fq[1].push_back(rnd_words[i]);
        end
        wait_frames(1, base + 16, 16 * (10 * BP_B + 3) + 100, "rand");
        for (int i = 0; i < 16; i++) begin
            if (pat_log[1].size() > base + i)
                check("rand_pattern", int'(pat_log[1][base + i]), int'(frame_of(rnd_words[i])));
        end
        check("rand_re_count", re_log[1].size() - rbase, 16);
        bad = 0;
        for (int i = base + 1; i < base + 16 && i < st_log[1].size(); i++) begin
            if (st_log[1][i] - st_log[1][i - 1] != 10 * BP_B + 3) bad++;
        end
        check("rand_frame_spacing", bad, 0);

        repeat (20) @(negedge clk);
        check("glitch_a", glitch_cnt[0], 0);
        check("glitch_b", glitch_cnt[1], 0);
        check("busy_profile_a", busy_err[0], 0);
        check("busy_profile_b", busy_err[1], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
